serial_tx_arbiter: RTL and testbench

SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

---
 rtl/serial_tx_arbiter_pkg.sv | 16 +
 rtl/serial_tx_arbiter_rr_arbiter.sv | 31 +++
 rtl/serial_tx_arbiter.sv | 106 ++++++++++
 tb/tb_serial_tx_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_arbiter_pkg.sv
// Shared definitions for the serial transmit arbiter: byte width, parameter
// defaults and the controller state encoding.
package serial_tx_arbiter_pkg;

  localparam int BYTE_W        = 8;
  localparam int NREQ_DEF      = 4;
  localparam int START_TMO_DEF = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LAUNCH     = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_tx_arbiter_rr_arbiter.sv
// Stateless round-robin search: the first asserted request after last_grant,
// wrapping modulo NREQ, wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_vld
);

  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last_grant) + i) % NREQ);
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one serial sender between NREQ byte requesters: round-robin grant,
// one-cycle start strobe, start timeout and completion tracking.
//
// state      | meaning
// IDLE       | waiting for a request while the sender is available
// LAUNCH     | tx_e strobe to the sender, byte already on tx_data
// WAIT_START | waiting for the sender to drop tx_avail, timeout running
// WAIT_DONE  | frame in flight, waiting for tx_avail to return high
module serial_tx_arbiter
  import serial_tx_arbiter_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int START_TMO = START_TMO_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [BYTE_W*NREQ-1:0]  data_in,
  output logic [NREQ-1:0]         ack,
  output logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_e,
  input  logic                    tx_avail,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(START_TMO + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(START_TMO - 1);

  state_t          state, state_nxt;
  logic [IW-1:0]   last_grant;
  logic [CW-1:0]   tmo_cnt;
  logic [NREQ-1:0] rr_grant;
  logic [IW-1:0]   rr_idx;
  logic            rr_vld;
  logic            do_grant;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .grant_idx  (rr_idx),
    .grant_vld  (rr_vld)
  );

  // ack is combinational in the grant cycle so it leads tx_e by one cycle
  assign do_grant = (state == IDLE) && tx_avail && rr_vld && !rst;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    ack       = '0;
    tx_e      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (do_grant) begin
          ack       = rr_grant;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_e      = 1'b1;
        state_nxt = WAIT_START;
      end
      WAIT_START: begin
        if (!tx_avail) begin
          state_nxt = WAIT_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (tx_avail) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_data    <= '0;
      grant_id   <= '0;
      last_grant <= IW'(NREQ - 1);
      tmo_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (do_grant) begin
        tx_data    <= data_in[rr_idx*BYTE_W +: BYTE_W];
        grant_id   <= rr_idx;
        last_grant <= rr_idx;
      end
      // held at zero outside WAIT_START so every entry starts a fresh count
      if (state == WAIT_START) tmo_cnt <= tmo_cnt + CW'(1);
      else                     tmo_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_serial_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int START_TMO = 4;
  localparam int IW        = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [7:0]      bytes [NREQ];
  logic [8*NREQ-1:0] data_in;
  logic [NREQ-1:0] ack;
  logic [7:0]      tx_data;
  logic            tx_e, tx_avail, busy, err;
  logic [IW-1:0]   grant_id;

  logic snd_busy = 1'b0;
  logic ext_hold = 1'b0;
  logic snd_dead = 1'b0;
  int   snd_frame = 5;
  int   snd_lat   = 0;

  int n_chk = 0, n_fail = 0, cyc = 0, auto_mode = 0;
  bit chk_en = 1'b0;
  int g_cyc[$], g_id[$], te_cyc[$], er_cyc[$];

  assign tx_avail = ~snd_busy & ~ext_hold;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign data_in[8*gi +: 8] = bytes[gi];
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_tx_arbiter #(.NREQ(NREQ), .START_TMO(START_TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .tx_data  (tx_data),
    .tx_e     (tx_e),
    .tx_avail (tx_avail),
    .busy     (busy),
    .grant_id (grant_id),
    .err      (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial sender stand-in: drops tx_avail snd_lat cycles after a strobe for snd_frame cycles.
  initial begin : sender
    int wait_c, left;
    logic r, te;
    wait_c = -1;
    left   = 0;
    forever begin
      @(negedge clk);
      r  = rst;
      te = tx_e;
      @(posedge clk); #1;
      if (r) begin
        snd_busy = 1'b0;
        wait_c   = -1;
        left     = 0;
      end else begin
        if (snd_busy) begin
          left--;
          if (left <= 0) snd_busy = 1'b0;
        end
        if (te === 1'b1 && !snd_dead) wait_c = snd_lat;
        if (wait_c == 0) begin
          snd_busy = 1'b1;
          left     = snd_frame;
          wait_c   = -1;
        end else if (wait_c > 0) begin
          wait_c--;
        end
      end
    end
  end

  // Reference model: one transfer at a time, tracked by its age since the grant.
  initial begin : model
    bit m_active, m_started;
    int m_age, m_last, m_gid, w, c;
    logic [7:0] m_data;
    logic [NREQ-1:0] e_ack;
    logic e_txe, e_err;
    m_active = 1'b0; m_started = 1'b0; m_age = 0;
    m_last = NREQ - 1; m_gid = 0; m_data = 8'h00;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_ack = '0; e_txe = 1'b0; e_err = 1'b0; w = -1;
        if (!m_active) begin
          if (!rst && tx_avail) begin
            for (int k = 1; k <= NREQ; k++) begin
              c = (m_last + k) % NREQ;
              if (w < 0 && req[c[IW-1:0]]) w = c;
            end
          end
          if (w >= 0) e_ack = NREQ'(1 << w);
        end else begin
          e_txe = (m_age == 1);
          e_err = !m_started && (m_age == START_TMO + 1) && tx_avail;
        end
        chk("busy",     32'(busy),     32'(m_active));
        chk("ack",      32'(ack),      32'(e_ack));
        chk("tx_e",     32'(tx_e),     32'(e_txe));
        chk("err",      32'(err),      32'(e_err));
        chk("tx_data",  32'(tx_data),  32'(m_data));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        for (int k = 0; k < NREQ; k++) begin
          if (ack === NREQ'(1 << k)) begin
            g_cyc.push_back(cyc);
            g_id.push_back(k);
          end
        end
        if (tx_e === 1'b1) te_cyc.push_back(cyc);
        if (err === 1'b1)  er_cyc.push_back(cyc);
        if (rst) begin
          m_active = 1'b0; m_last = NREQ - 1; m_gid = 0; m_data = 8'h00;
        end else if (!m_active) begin
          if (w >= 0) begin
            m_active = 1'b1; m_age = 1; m_started = 1'b0;
            m_last = w; m_gid = w; m_data = bytes[w[IW-1:0]];
          end
        end else begin
          if (m_age >= 2) begin
            if (m_started) begin
              if (tx_avail) m_active = 1'b0;
            end else if (!tx_avail) begin
              m_started = 1'b1;
            end else if (e_err) begin
              m_active = 1'b0;
            end
          end
          m_age++;
        end
      end
    end
  end

  task automatic step();
    logic [NREQ-1:0] a;
    @(negedge clk);
    a = ack;
    @(posedge clk); #1;
    req = req & ~a;
    for (int k = 0; k < NREQ; k++) begin
      if (auto_mode == 2) begin
        if (a[k[IW-1:0]]) bytes[k[IW-1:0]] = 8'($urandom);
        req[k[IW-1:0]] = 1'b1;
      end else if (auto_mode == 1 && !req[k[IW-1:0]] && $urandom_range(0, 3) == 0) begin
        bytes[k[IW-1:0]] = 8'($urandom);
        req[k[IW-1:0]]   = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; auto_mode = 0; req = '0; ext_hold = 1'b0; snd_dead = 1'b0;
    step();
    step();
    rst = 1'b0;
    g_cyc.delete(); g_id.delete(); te_cyc.delete(); er_cyc.delete();
  endtask

  task automatic wait_grants(input int n, input int budget, input string name);
    for (int i = 0; i < budget && g_id.size() < n; i++) step();
    chk(name, 32'(g_id.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget && busy; i++) step();
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int gc, rc;
    for (int k = 0; k < NREQ; k++) bytes[k[IW-1:0]] = 8'h00;
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_reset();

    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'h00);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_ack",      32'(ack),      32'd0);
    chk("rst_tx_e",     32'(tx_e),     32'd0);
    chk("rst_err",      32'(err),      32'd0);

    // single request from requester 2
    snd_frame = 5; snd_lat = 0;
    for (int k = 0; k < NREQ; k++) bytes[k[IW-1:0]] = 8'($urandom);
    bytes[2] = 8'hA5;
    req = 4'b0100;
    wait_grants(1, 10, "A_grant_wait");
    if (g_id.size() >= 1) begin
      gc = g_cyc[0];
      chk("A_id",      32'(g_id[0]), 32'd2);
      chk("A_tx_data", 32'(tx_data), 32'hA5);
      chk("A_tx_e",    32'(tx_e),    32'd1);
      wait_idle(30, "A_idle_wait");
      chk("A_done_cyc", 32'(cyc - gc), 32'd8);
      chk("A_txe_lag",  32'(te_cyc.size() >= 1 ? te_cyc[0] - gc : -1), 32'd1);
      chk("A_hold",     32'(tx_data), 32'hA5);
    end

    // all requesting, 20-cycle frames
    do_reset();
    snd_frame = 20; snd_lat = 0; auto_mode = 2; req = '1;
    wait_grants(5, 200, "B_grant_wait");
    if (g_id.size() >= 5 && te_cyc.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("B_order",   32'(g_id[k]), 32'(k % NREQ));
        chk("B_ack_txe", 32'(te_cyc[k] - g_cyc[k]), 32'd1);
      end
      for (int k = 0; k < 4; k++) chk("B_spacing", 32'(te_cyc[k+1] - te_cyc[k]), 32'd23);
    end
    auto_mode = 0; req = '0;
    wait_idle(40, "B_idle_wait");

    // sender never starts
    do_reset();
    snd_dead = 1'b1; req = 4'b0011;
    wait_grants(2, 30, "C_grant_wait");
    if (g_id.size() >= 2 && er_cyc.size() >= 1 && te_cyc.size() >= 1) begin
      chk("C_first",   32'(g_id[0]), 32'd0);
      chk("C_err_lag", 32'(er_cyc[0] - te_cyc[0]), 32'(START_TMO));
      chk("C_next",    32'(g_id[1]), 32'd1);
      chk("C_regrant", 32'(g_cyc[1] - er_cyc[0]), 32'd1);
    end
    req = '0;
    wait_idle(20, "C_idle_wait");
    snd_dead = 1'b0;

    // sender busy from elsewhere
    do_reset();
    ext_hold = 1'b1; req = 4'b0001;
    repeat (10) step();
    chk("D_no_ack",  32'(g_id.size()),   32'd0);
    chk("D_no_txe",  32'(te_cyc.size()), 32'd0);
    ext_hold = 1'b0;
    rc = cyc;
    step();
    chk("D_grant_cnt", 32'(g_id.size()), 32'd1);
    if (g_id.size() >= 1) begin
      chk("D_id",  32'(g_id[0]),  32'd0);
      chk("D_cyc", 32'(g_cyc[0]), 32'(rc));
    end
    wait_idle(30, "D_idle_wait");

    // reset during WAIT_DONE
    do_reset();
    snd_frame = 30; snd_lat = 0;
    bytes[2] = 8'h3C; req = 4'b0100;
    wait_grants(1, 10, "E_grant_wait");
    repeat (6) step();
    chk("E_busy_pre",  32'(busy),     32'd1);
    chk("E_avail_pre", 32'(tx_avail), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1001;
    chk("E_busy_rst",    32'(busy),     32'd0);
    chk("E_tx_data_rst", 32'(tx_data),  32'h00);
    chk("E_gid_rst",     32'(grant_id), 32'd0);
    wait_grants(2, 10, "E_regrant_wait");
    if (g_id.size() >= 2) chk("E_regrant_id", 32'(g_id[1]), 32'd0);
    req = '0;
    wait_idle(60, "E_idle_wait");

    // randomized traffic with timeouts, foreign busy periods and resets
    do_reset();
    auto_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      snd_frame = $urandom_range(1, 6);
      snd_lat   = ($urandom_range(0, 7) == 0) ? START_TMO : $urandom_range(0, START_TMO - 1);
      if ($urandom_range(0, 19) == 0) ext_hold = ~ext_hold;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; auto_mode = 0; req = '0; ext_hold = 1'b0;
    wait_idle(40, "R_idle_wait");
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
